// File: rtl/decode_ctrl_pipe.sv
// RV32IM decode-control pipeline stage: registers the execute/memory/writeback control
// bundle behind a valid/ready handshake and throttles issue during multi-cycle M-ops.
module decode_ctrl_pipe #(
  parameter int unsigned EN_M    = 1,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = $clog2(DIV_LAT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alu_ctrl,
  output logic        branch,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        alu_src,
  output logic        alu_pc_src,
  output logic        reg_write,
  output logic        pc_jalr,
  output logic        illegal,
  output logic        busy
);

  localparam logic [4:0] ALUCTRL_NOP    = 5'd0;
  localparam logic [4:0] ALUCTRL_ADD    = 5'd1;
  localparam logic [4:0] ALUCTRL_SUB    = 5'd2;
  localparam logic [4:0] ALUCTRL_SLL    = 5'd3;
  localparam logic [4:0] ALUCTRL_SLT    = 5'd4;
  localparam logic [4:0] ALUCTRL_SLTU   = 5'd5;
  localparam logic [4:0] ALUCTRL_XOR    = 5'd6;
  localparam logic [4:0] ALUCTRL_SRL    = 5'd7;
  localparam logic [4:0] ALUCTRL_SRA    = 5'd8;
  localparam logic [4:0] ALUCTRL_OR     = 5'd9;
  localparam logic [4:0] ALUCTRL_AND    = 5'd10;
  localparam logic [4:0] ALUCTRL_MUL    = 5'd11;
  localparam logic [4:0] ALUCTRL_MULH   = 5'd12;
  localparam logic [4:0] ALUCTRL_MULHSU = 5'd13;
  localparam logic [4:0] ALUCTRL_MULHU  = 5'd14;
  localparam logic [4:0] ALUCTRL_DIV    = 5'd15;
  localparam logic [4:0] ALUCTRL_DIVU   = 5'd16;
  localparam logic [4:0] ALUCTRL_REM    = 5'd17;
  localparam logic [4:0] ALUCTRL_REMU   = 5'd18;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Counter load values are latency-1: the accept cycle itself counts as the first.
  // MUL_LAT is assumed not to exceed DIV_LAT, since CNT_W is sized from DIV_LAT.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic {StIdle, StBusy} state_t;

  function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
    logic [4:0] a;
    unique case (f3)
      3'b000:  a = alt ? ALUCTRL_SUB : ALUCTRL_ADD;
      3'b001:  a = ALUCTRL_SLL;
      3'b010:  a = ALUCTRL_SLT;
      3'b011:  a = ALUCTRL_SLTU;
      3'b100:  a = ALUCTRL_XOR;
      3'b101:  a = alt ? ALUCTRL_SRA : ALUCTRL_SRL;
      3'b110:  a = ALUCTRL_OR;
      default: a = ALUCTRL_AND;
    endcase
    return a;
  endfunction

  function automatic logic [4:0] m_alu(input logic [2:0] f3);
    logic [4:0] a;
    unique case (f3)
      3'b000:  a = ALUCTRL_MUL;
      3'b001:  a = ALUCTRL_MULH;
      3'b010:  a = ALUCTRL_MULHSU;
      3'b011:  a = ALUCTRL_MULHU;
      3'b100:  a = ALUCTRL_DIV;
      3'b101:  a = ALUCTRL_DIVU;
      3'b110:  a = ALUCTRL_REM;
      default: a = ALUCTRL_REMU;
    endcase
    return a;
  endfunction

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd;
  logic       w_unused;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  assign w_unused = ^in_instr[24:15];

  // Raw decode, before the legality mask and x0 suppression.
  logic [4:0] w_alu;
  logic       w_branch, w_mem_to_reg, w_mem_write, w_alu_src, w_alu_pc_src;
  logic       w_reg_write, w_pc_jalr, w_legal, w_m_op;

  always_comb begin
    w_alu        = ALUCTRL_NOP;
    w_branch     = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_pc_src = 1'b0;
    w_reg_write  = 1'b0;
    w_pc_jalr    = 1'b0;
    w_legal      = 1'b0;
    w_m_op       = 1'b0;
    unique case (w_opcode)
      OP_R: begin
        w_reg_write = 1'b1;
        unique case (w_funct7)
          7'b0000000: begin
            w_legal = 1'b1;
            w_alu   = base_alu(w_funct3, 1'b0);
          end
          7'b0100000: begin
            w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
            w_alu   = base_alu(w_funct3, 1'b1);
          end
          7'b0000001: begin
            w_legal = (EN_M != 0);
            w_m_op  = (EN_M != 0);
            w_alu   = m_alu(w_funct3);
          end
          default: w_legal = 1'b0;
        endcase
      end
      OP_IMM: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_legal     = (w_funct3 != 3'b001 && w_funct3 != 3'b101) || (w_funct7 == 7'b0000000) ||
                      (w_funct3 == 3'b101 && w_funct7 == 7'b0100000);
        w_alu       = base_alu(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
      end
      OP_AUIPC: begin
        w_legal      = 1'b1;
        w_alu        = ALUCTRL_ADD;
        w_alu_src    = 1'b1;
        w_alu_pc_src = 1'b1;
        w_reg_write  = 1'b1;
      end
      OP_LOAD: begin
        w_legal      = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
        w_alu        = ALUCTRL_ADD;
        w_alu_src    = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      OP_STORE: begin
        w_legal     = !w_funct3[2] && (w_funct3 != 3'b011);
        w_alu       = ALUCTRL_ADD;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      OP_BRANCH: begin
        w_legal  = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
        w_branch = 1'b1;
        // BEQ/BNE compare by subtraction; BLT/BGE and BLTU/BGEU by set-less-than.
        if (!w_funct3[2]) begin
          w_alu = ALUCTRL_SUB;
        end else begin
          w_alu = w_funct3[1] ? ALUCTRL_SLTU : ALUCTRL_SLT;
        end
      end
      OP_JAL, OP_JALR: begin
        w_legal      = 1'b1;
        w_alu        = ALUCTRL_ADD;
        w_branch     = 1'b1;
        w_alu_src    = 1'b1;
        w_alu_pc_src = 1'b1;
        w_reg_write  = 1'b1;
        w_pc_jalr    = (w_opcode == OP_JALR);
      end
      default: w_legal = 1'b0;
    endcase
  end

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_out_valid;
  logic             w_accept;
  logic [CNT_W-1:0] w_m_load;

  assign in_ready = !rst && !flush && (r_state == StIdle) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_m_load = w_funct3[2] ? DIV_LOAD : MUL_LOAD;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept && w_legal && w_m_op) begin
          w_cnt_next = w_m_load;
          if (w_m_load != '0) begin
            w_state_next = StBusy;
          end
        end
      end
      StBusy: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
    if (flush) begin
      w_state_next = StIdle;
      w_cnt_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  logic [4:0] r_alu_ctrl;
  logic       r_branch, r_mem_to_reg, r_mem_write, r_alu_src, r_alu_pc_src;
  logic       r_reg_write, r_pc_jalr, r_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_alu_ctrl   <= ALUCTRL_NOP;
      r_branch     <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_pc_src <= 1'b0;
      r_reg_write  <= 1'b0;
      r_pc_jalr    <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      // Illegal encodings still issue, but with a neutral control bundle.
      r_out_valid  <= 1'b1;
      r_alu_ctrl   <= w_legal ? w_alu : ALUCTRL_NOP;
      r_branch     <= w_legal && w_branch;
      r_mem_to_reg <= w_legal && w_mem_to_reg;
      r_mem_write  <= w_legal && w_mem_write;
      r_alu_src    <= w_legal && w_alu_src;
      r_alu_pc_src <= w_legal && w_alu_pc_src;
      r_reg_write  <= w_legal && w_reg_write && (w_rd != 5'd0);
      r_pc_jalr    <= w_legal && w_pc_jalr;
      r_illegal    <= !w_legal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign alu_ctrl   = r_alu_ctrl;
  assign branch     = r_branch;
  assign mem_to_reg = r_mem_to_reg;
  assign mem_write  = r_mem_write;
  assign alu_src    = r_alu_src;
  assign alu_pc_src = r_alu_pc_src;
  assign reg_write  = r_reg_write;
  assign pc_jalr    = r_pc_jalr;
  assign illegal    = r_illegal;
  assign busy       = (r_state == StBusy);

endmodule
